// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, with sign correction applied once in the FINISH state.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  divByZero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [W-1:0]    mag_a_q, mag_a_d;
  logic [W-1:0]    mag_b_q, mag_b_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            done_q, done_d;
  logic            dbz_q, dbz_d;

  // op[1] selects divide, op[0] selects signed interpretation
  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      mul_sum;
  logic [2*W:0]    div_shift;
  logic [W:0]      div_diff;
  logic [2*W-1:0]  prod_neg;
  logic [W-1:0]    quot_neg, rem_neg, dbz_hi;

  assign a_neg     = op[0] & a[W-1];
  assign b_neg     = op[0] & b[W-1];
  assign a_mag     = a_neg ? (~a + 1'b1) : a;
  assign b_mag     = b_neg ? (~b + 1'b1) : b;

  // Multiplier lives in the low half and is consumed LSB first.
  assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag_a_q} : {(W+1){1'b0}});
  // Dividend shifts out of the low half into the partial remainder; quotient bits fill in.
  assign div_shift = {acc_q, 1'b0};
  assign div_diff  = div_shift[2*W:W] - {1'b0, mag_b_q};

  assign prod_neg  = ~acc_q + 1'b1;
  assign quot_neg  = ~acc_q[W-1:0] + 1'b1;
  assign rem_neg   = ~acc_q[2*W-1:W] + 1'b1;
  // Divide by zero returns the original dividend, rebuilt from its magnitude.
  assign dbz_hi    = neg_rem_q ? (~mag_a_q + 1'b1) : mag_a_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op;
          mag_a_d   = a_mag;
          mag_b_d   = b_mag;
          acc_d     = op[1] ? {{W{1'b0}}, a_mag} : {{W{1'b0}}, b_mag};
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          cnt_d     = '0;
          dbz_d     = 1'b0;
          state_d   = CALC;
        end
      end
      CALC: begin
        if (op_q[1]) begin
          if (!div_diff[W]) acc_d = {div_diff[W-1:0], div_shift[W-1:1], 1'b1};
          else              acc_d = div_shift[2*W-1:0];
        end else begin
          acc_d = {mul_sum, acc_q[W-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) state_d = FINISH;
      end
      FINISH: begin
        if (!op_q[1]) begin
          {hi_d, lo_d} = neg_res_q ? prod_neg : acc_q;
        end else if (mag_b_q == '0) begin
          hi_d  = dbz_hi;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          lo_d = neg_res_q ? quot_neg : acc_q[W-1:0];
          hi_d = neg_rem_q ? rem_neg  : acc_q[2*W-1:W];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign divByZero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit at DATA_WIDTH=32: results, latency,
// divide-by-zero, back-to-back starts and mid-operation reset.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

  logic         clock = 1'b0;
  logic         resetn = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, divByZero;
  logic [W-1:0] hi, lo;

  int tests_run = 0;
  int tests_failed = 0;

  mult_div_unit #(.DATA_WIDTH(W)) dut (
    .clock(clock), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .divByZero(divByZero)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Waits for done (sampled 1 time unit after each edge); returns edges elapsed.
  task automatic wait_done(input string tag, input bit scramble, output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      if (scramble) begin
        a  = $urandom;
        b  = $urandom;
        op = 2'($urandom_range(3));
      end
      @(posedge clock); #1;
      lat++;
    end
    check_val({tag, "_latency"}, 64'(lat), 64'(33));
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] opa,
                        input logic [W-1:0] opb, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input logic exp_dbz);
    int lat;
    @(negedge clock);
    start = 1'b1; op = o; a = opa; b = opb;
    @(posedge clock); #1;
    start = 1'b0;
    check_val({tag, "_busy"}, 64'(busy), 64'(1));
    check_val({tag, "_dbz_clr"}, 64'(divByZero), 64'(0));
    wait_done(tag, 1'b1, lat);
    check_val({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check_val({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    check_val({tag, "_dbz"}, 64'(divByZero), 64'(exp_dbz));
    $display("[TB] %s op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0b lat=%0d",
             tag, o, opa, opb, hi, lo, divByZero, lat);
  endtask

  initial begin
    int lat;
    int done_cnt;
    logic [W-1:0] hi_before;

    #3 resetn = 1'b0;
    #1;
    check_val("rst_busy", 64'(busy), 64'(0));
    check_val("rst_done", 64'(done), 64'(0));
    check_val("rst_hi", 64'(hi), 64'(0));
    check_val("rst_lo", 64'(lo), 64'(0));
    check_val("rst_dbz", 64'(divByZero), 64'(0));
    @(negedge clock); @(negedge clock);
    resetn = 1'b1;

    run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("multu_shift", MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0);
    run_op("mult_neg", MULT, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("mult_negneg", MULT, 32'hFFFFFFFC, 32'hFFFFFFFB, 32'h00000000, 32'h00000014, 1'b0);
    run_op("mult_minx2", MULT, 32'h80000000, 32'd2, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    run_op("div_negpos", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div_posneg", DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run_op("divu_by0", DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1);
    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("div_min_m1", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op("div_neg_by0", DIV, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7, 32'hFFFFFFFF, 1'b1);
    run_op("divu_max_1", DIVU, 32'hFFFFFFFF, 32'd1, 32'h00000000, 32'hFFFFFFFF, 1'b0);

    // start held high throughout; operands scrambled while busy
    @(negedge clock);
    start = 1'b1; op = MULTU; a = 32'd3; b = 32'd5;
    @(posedge clock); #1;
    hi_before = lo;
    wait_done("b2b_first", 1'b1, lat);
    check_val("b2b_first_hi", 64'(hi), 64'(0));
    check_val("b2b_first_lo", 64'(lo), 64'(15));
    check_val("b2b_hold_lo", 64'(hi_before), 64'(32'hFFFFFFFF));
    $display("[TB] b2b_first MULTU 3*5 -> hi=%h lo=%h lat=%0d", hi, lo, lat);
    op = DIVU; a = 32'd50; b = 32'd6;
    @(posedge clock); #1;
    check_val("b2b_accept_busy", 64'(busy), 64'(1));
    check_val("b2b_accept_done", 64'(done), 64'(0));
    wait_done("b2b_second", 1'b1, lat);
    start = 1'b0;
    check_val("b2b_second_hi", 64'(hi), 64'(2));
    check_val("b2b_second_lo", 64'(lo), 64'(8));
    $display("[TB] b2b_second DIVU 50/6 -> hi=%h lo=%h lat=%0d", hi, lo, lat);

    // reset during CALC iteration 10 of a MULT
    @(negedge clock);
    start = 1'b1; op = MULT; a = 32'hFFFFFFFB; b = 32'd9;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1 resetn = 1'b0;
    #1;
    check_val("abort_busy", 64'(busy), 64'(0));
    check_val("abort_hi", 64'(hi), 64'(0));
    check_val("abort_lo", 64'(lo), 64'(0));
    check_val("abort_done", 64'(done), 64'(0));
    @(negedge clock); @(negedge clock);
    resetn = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (done) done_cnt++;
    end
    check_val("abort_no_done", 64'(done_cnt), 64'(0));
    $display("[TB] abort MULT at iteration 10 -> done pulses after release=%0d", done_cnt);
    run_op("multu_6x7", MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
